// File: rtl/reveal_ctrl.sv
// Album-art reveal sequencer: steps a cell counter while the song plays,
// debounces skip buttons and captures the border colour of the current cell.
module reveal_ctrl #(
    parameter int TICK_DIV  = 3000000,
    parameter int PIX_TOTAL = 2500,
    parameter int LOCKOUT   = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_next,
    input  logic        i_pre,
    input  logic        i_finish_song,
    input  logic        i_playing,
    input  logic        i_sample_valid,
    input  logic [14:0] i_sample_addr,
    input  logic [11:0] i_sample_rgb,
    output logic [14:0] o_reveal_cnt,
    output logic [1:0]  o_state,
    output logic        o_done,
    output logic        o_skip_evt,
    output logic        o_skip_dir,
    output logic [11:0] o_round_rgb,
    output logic        o_round_valid
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [14:0]   PIX_LAST  = 15'(PIX_TOTAL);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [14:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          next_prev_q, pre_prev_q;
    logic          skip_evt_q, skip_evt_d;
    logic          skip_dir_q, skip_dir_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic rise_next, rise_pre, lock_free, acc_next, acc_pre, accept, restart, incr;

    // Next wins a tie; both edges are swallowed while the lockout runs.
    always_comb begin
        rise_next = i_next & ~next_prev_q;
        rise_pre  = i_pre & ~pre_prev_q;
        lock_free = (lock_q == '0);
        acc_next  = rise_next & lock_free;
        acc_pre   = rise_pre & ~rise_next & lock_free;
        accept    = acc_next | acc_pre;
        restart   = accept | i_finish_song;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        rgb_d      = rgb_q;
        valid_d    = valid_q;
        incr       = 1'b0;
        skip_evt_d = accept;
        skip_dir_d = accept ? acc_next : skip_dir_q;
        if (accept)
            lock_d = LOCK_LOAD;
        else if (!lock_free)
            lock_d = lock_q - 1'b1;
        else
            lock_d = lock_q;

        if (restart) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (i_playing) state_d = S_RUN;
                S_RUN: begin
                    // A pause wins over a tick landing in the same cycle.
                    if (!i_playing) begin
                        state_d = S_HOLD;
                    end else if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        cnt_d   = cnt_q + 15'd1;
                        incr    = 1'b1;
                        if (cnt_d == PIX_LAST) state_d = S_DONE;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_HOLD: if (i_playing) state_d = S_RUN;
                default: ;
            endcase
        end

        // Colour is kept across restarts; only the valid flag drops.
        if (restart || incr)
            valid_d = 1'b0;
        else if (i_sample_valid && (i_sample_addr == cnt_q) && !valid_q) begin
            rgb_d   = i_sample_rgb;
            valid_d = 1'b1;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            presc_q     <= '0;
            lock_q      <= '0;
            next_prev_q <= 1'b0;
            pre_prev_q  <= 1'b0;
            skip_evt_q  <= 1'b0;
            skip_dir_q  <= 1'b0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            lock_q      <= lock_d;
            next_prev_q <= i_next;
            pre_prev_q  <= i_pre;
            skip_evt_q  <= skip_evt_d;
            skip_dir_q  <= skip_dir_d;
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign o_reveal_cnt  = cnt_q;
    assign o_state       = state_q;
    assign o_done        = done_q;
    assign o_skip_evt    = skip_evt_q;
    assign o_skip_dir    = skip_dir_q;
    assign o_round_rgb   = rgb_q;
    assign o_round_valid = valid_q;
endmodule
